// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and helper functions for the MIPS data memory.
//
// Contents:
//   size_e     access size encoding on req_size (byte / half / word / reserved)
//   state_e    controller state (INIT clear walk, RUN normal traffic)
//   store_t    byte-enable mask plus lane-replicated write data
//   misaligned()    1 when a size/lane pair cannot be serviced
//   load_extract()  pick the addressed byte/half out of a word and extend it
//   store_gen()     byte enables and replicated data for a store
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } store_t;

    // Reserved size is always rejected; halves need an even lane, words lane 0.
    function automatic logic misaligned(input size_e size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the addressed lane(s) down to bit 0, then sign- or zero-extend.
    // Word loads return the word untouched regardless of uns.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input size_e       size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: result = uns ? {24'h000000, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = uns ? {16'h0000, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: result = word;
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    // Replicate the right-aligned store data across all lanes so each lane
    // array can take its slice directly; the enable mask picks the live lanes.
    function automatic store_t store_gen(input size_e       size,
                                         input logic [1:0]  lane,
                                         input logic [31:0] wdata);
        store_t st;
        case (size)
            SZ_BYTE: begin
                st.be   = 4'b0001 << lane;
                st.data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                st.be   = lane[1] ? 4'b1100 : 4'b0011;
                st.data = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                st.be   = 4'b1111;
                st.data = wdata;
            end
            default: begin
                st.be   = 4'b0000;
                st.data = 32'h0000_0000;
            end
        endcase
        return st;
    endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe -- fixed-latency response delay line for the data memory.
//
// Stage 0 captures {valid, rdata, err} at the request acceptance edge; the
// last stage drives the response outputs, giving a LAT-cycle response.
// Every stage is cleared asynchronously by rst so in-flight responses vanish.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_rdata/in_err     response captured at acceptance
//   out_valid/out_rdata/out_err  response after LAT stages
module dmem_rsp_pipe #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_rdata,
    input  logic        in_err,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    logic [LAT-1:0]        valid_reg;
    logic [LAT-1:0][31:0]  rdata_reg;
    logic [LAT-1:0]        err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= '0;
        end else begin
            valid_reg[0] <= in_valid;
            rdata_reg[0] <= in_rdata;
            err_reg[0]   <= in_err;
            for (int i = 1; i < LAT; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                rdata_reg[i] <= rdata_reg[i-1];
                err_reg[i]   <= err_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[LAT-1];
    assign out_rdata = rdata_reg[LAT-1];
    assign out_err   = err_reg[LAT-1];

endmodule

// File: rtl/mips_dmem_ctrl.sv
// mips_dmem_ctrl -- byte-addressed little-endian data memory for the MIPS
// MEM stage. DEPTH 32-bit words, LB/LBU/LH/LHU/LW/SB/SH/SW over a
// valid/ready request channel, in-order responses READ_LAT cycles later.
// After reset the array is cleared by a one-word-per-cycle walk (INIT);
// requests are refused until it finishes.
//
// Optional build macro: DMEM_OOR_ERR_EN -- when defined, byte addresses with
// any bit set above the decoded range are rejected with rsp_err; otherwise
// they alias modulo 4*DEPTH bytes.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only in RUN)
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned    zero-extend (1) or sign-extend (0) narrow loads
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   rsp_valid       one-cycle pulse per accepted request
//   rsp_rdata       extended load data (0 for stores and errors)
//   rsp_err         access rejected
//   init_busy       array clear in progress
module mips_dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_busy
);

    localparam int WORD_AW = $clog2(DEPTH);
    localparam int ADDR_W  = WORD_AW + 2;

    // ---------------- INIT / RUN sequencing ----------------
    state_e               state_reg, state_next;
    logic [WORD_AW-1:0]   cnt_reg, cnt_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_INIT) begin
            cnt_next = cnt_reg + WORD_AW'(1);
            if (cnt_reg == WORD_AW'(DEPTH - 1)) begin
                state_next = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign req_ready = (state_reg == ST_RUN);
    assign init_busy = (state_reg == ST_INIT);

    // ---------------- request decode ----------------
    size_e               req_sz;
    logic [WORD_AW-1:0]  idx;
    logic [1:0]          lane;
    logic                oor;
    logic                acc_err;
    logic                accept;
    store_t              st;

    assign req_sz = size_e'(req_size);
    assign idx    = req_addr[ADDR_W-1:2];
    assign lane   = req_addr[1:0];

`ifdef DMEM_OOR_ERR_EN
    assign oor = |req_addr[31:ADDR_W];
`else
    // High address bits are deliberately ignored: the array aliases.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
    assign oor            = 1'b0;
`endif

    assign acc_err = misaligned(req_sz, lane) | oor;
    assign accept  = req_valid & req_ready;
    assign st      = store_gen(req_sz, lane, req_wdata);

    // ---------------- single write port shared by INIT and stores ----------------
    logic                wr_en;
    logic [WORD_AW-1:0]  wr_idx;
    logic [3:0]          wr_be;
    logic [31:0]         wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = st.be;
        wr_data = st.data;
        if (state_reg == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_reg;
            wr_be   = 4'hF;
            wr_data = '0;
        end else if (accept && req_we && !acc_err) begin
            wr_en = 1'b1;
        end
    end

    // One byte-wide array per lane so partial stores need no read-modify-write.
    // The read value is captured by the response pipe at the acceptance edge.
    logic [31:0] rd_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    mem_lane[wr_idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem_lane[idx];
        end
    endgenerate

    // ---------------- response ----------------
    logic        pipe_valid;
    logic [31:0] pipe_rdata;
    logic        pipe_err;

    assign pipe_valid = accept;
    assign pipe_err   = accept & acc_err;
    assign pipe_rdata = (accept && !req_we && !acc_err)
                      ? load_extract(rd_word, req_sz, lane, req_unsigned)
                      : 32'h0000_0000;

    dmem_rsp_pipe #(
        .LAT (READ_LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pipe_valid),
        .in_rdata  (pipe_rdata),
        .in_err    (pipe_err),
        .out_valid (rsp_valid),
        .out_rdata (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// tb_mips_dmem_ctrl -- directed and randomized checks of mips_dmem_ctrl
// against a byte-array reference model with a queue of expected responses.
module tb_mips_dmem_ctrl;

    localparam int DEPTH    = 256;
    localparam int READ_LAT = 3;
    localparam int NBYTES   = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    always #5 clk = ~clk;

    mips_dmem_ctrl #(
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_busy    (init_busy)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          since_rel = 0;
    logic [7:0]  mmem [NBYTES];
    rsp_t        q [$];
    bit          use_dir   = 1'b0;
    logic [31:0] dir_d;
    logic        dir_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory as a flat little-endian byte array; sizes in bytes.
    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] data, output logic err);
        int          nb;
        int          ba;
        logic [31:0] val;
        nb  = (size == 2'd3) ? 0 : (1 << size);
        err = (nb == 0);
        if (!err) err = ((int'(addr[1:0]) % nb) != 0);
`ifdef DMEM_OOR_ERR_EN
        if (addr >= 32'(NBYTES)) err = 1'b1;
`endif
        ba   = int'(addr % 32'(NBYTES));
        data = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < nb; k++) mmem[ba+k] = wdata[8*k +: 8];
            end else begin
                val = 32'h0;
                for (int k = 0; k < nb; k++) val = val | (32'(mmem[ba+k]) << (8*k));
                if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
                data = val;
            end
        end
    endtask

    task automatic check_outputs();
        rsp_t r;
        chk("init_busy", 32'(init_busy), 32'(since_rel < DEPTH));
        chk("req_ready", 32'(req_ready), 32'(since_rel >= DEPTH));
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1));
            chk("rsp_rdata", rsp_rdata, r.data);
            chk("rsp_err",   32'(rsp_err), 32'(r.err));
            $display("rsp cyc=%0d rdata=%h err=%0b", cyc, rsp_rdata, rsp_err);
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'(0));
            chk("rsp_rdata_idle", rsp_rdata, 32'h0);
            chk("rsp_err_idle",   32'(rsp_err), 32'(0));
        end
    endtask

    // One clock: decide acceptance from the model, step, check at negedge.
    task automatic do_cycle();
        logic [31:0] d;
        logic        e;
        rsp_t        r;
        if (req_valid && !rst && since_rel >= DEPTH) begin
            model_access(req_we, req_size, req_unsigned, req_addr, req_wdata, d, e);
            if (use_dir) begin
                d = dir_d;
                e = dir_e;
            end
            r.due  = cyc + READ_LAT;
            r.data = d;
            r.err  = e;
            q.push_back(r);
            $display("txn cyc=%0d we=%0b size=%0d uns=%0b addr=%h wdata=%h exp_rdata=%h exp_err=%0b",
                     cyc + 1, req_we, req_size, req_unsigned, req_addr, req_wdata, d, e);
        end
        @(posedge clk);
        cyc++;
        if (!rst) since_rel++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic req(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        do_cycle();
        req_valid    = 1'b0;
    endtask

    // Directed request whose response is checked against a literal value.
    task automatic dreq(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input logic exp_e);
        use_dir = 1'b1;
        dir_d   = exp_d;
        dir_e   = exp_e;
        req(we, size, uns, addr, wdata);
        use_dir = 1'b0;
    endtask

    // Called at a negedge; outputs must react to rst without a clock edge.
    task automatic apply_reset();
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        q.delete();
        for (int i = 0; i < NBYTES; i++) mmem[i] = 8'h00;
        since_rel = 0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   32'(rsp_err), 32'(0));
        chk("rst_init_busy", 32'(init_busy), 32'(1));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        idle(2);
        rst = 1'b0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < DEPTH + 4 && since_rel < DEPTH; i++) do_cycle();
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        @(negedge clk);

        // Reset, then a load held during INIT must be ignored.
        apply_reset();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h10;
        idle(10);
        req_valid = 1'b0;
        wait_init();
        dreq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0);

        // Word store, byte merge, word readback (back-to-back).
        dreq(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        dreq(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB, 32'h0, 1'b0);
        dreq(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         32'h1122_AB44, 1'b0);

        // Narrow loads with sign/zero extension.
        dreq(1'b1, 2'd2, 1'b0, 32'h40, 32'h80FF_7F01, 32'h0, 1'b0);
        dreq(1'b0, 2'd0, 1'b0, 32'h42, 32'h0, 32'hFFFF_FFFF, 1'b0);
        dreq(1'b0, 2'd0, 1'b1, 32'h42, 32'h0, 32'h0000_00FF, 1'b0);
        dreq(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 32'hFFFF_80FF, 1'b0);
        dreq(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 32'h0000_7F01, 1'b0);
        dreq(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h0000_0001, 1'b0);
        dreq(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 32'h0000_80FF, 1'b0);

        // Error cases leave the array untouched.
        dreq(1'b0, 2'd2, 1'b0, 32'h22, 32'h0,         32'h0, 1'b1);
        dreq(1'b1, 2'd1, 1'b0, 32'h23, 32'hDEAD_BEEF, 32'h0, 1'b1);
        dreq(1'b1, 2'd3, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b1);
        dreq(1'b1, 2'd2, 1'b0, 32'h21, 32'hDEAD_BEEF, 32'h0, 1'b1);
        dreq(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         32'h1122_AB44, 1'b0);

        // High address bits: error or alias depending on the build.
`ifdef DMEM_OOR_ERR_EN
        dreq(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b1);
        dreq(1'b0, 2'd2, 1'b0, 32'h0,   32'h0,         32'h0, 1'b0);
`else
        dreq(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0);
        dreq(1'b0, 2'd2, 1'b0, 32'h0,   32'h0,         32'hCAFE_F00D, 1'b0);
`endif
        idle(READ_LAT + 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            int r;
            req_valid    = ($urandom_range(0, 3) != 0);
            req_we       = $urandom_range(0, 1) != 0;
            req_size     = 2'($urandom_range(0, 3));
            req_unsigned = $urandom_range(0, 1) != 0;
            r            = $urandom_range(0, 9);
            if (r == 0)      req_addr = $urandom;
            else if (r < 6)  req_addr = 32'($urandom_range(0, 63));
            else             req_addr = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 1) != 0 && req_size != 2'd3)
                req_addr = req_addr & ~((32'd1 << req_size) - 32'd1);
            req_wdata    = $urandom;
            do_cycle();
        end
        req_valid = 1'b0;
        idle(READ_LAT + 1);

        // Reset with two loads in flight: no responses, INIT restarts, data cleared.
        dreq(1'b1, 2'd2, 1'b0, 32'h80, 32'h5555_AAAA, 32'h0, 1'b0);
        dreq(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h5555_AAAA, 1'b0);
        dreq(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h5555_AAAA, 1'b0);
        apply_reset();
        wait_init();
        dreq(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h0000_0000, 1'b0);
        dreq(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0000_0000, 1'b0);
        idle(READ_LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_dmem_ctrl.md
Name: mips_dmem_ctrl

Overview:
- Parametrised next-generation data memory for the MIPS datapath.
- Byte-addressed, little-endian, 32-bit word array of DEPTH words.
- Supports byte/halfword/word loads and stores (LB/LBU/LH/LHU/LW, SB/SH/SW) over a valid/ready request channel and an in-order response pipe of configurable latency.
- Clears the array after reset with a sequential init walk instead of a single-cycle array reset; sits between the MEM stage and the memory array.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- READ_LAT, 1, cycles from request acceptance to response; at least 1.
- Derived localparam WORD_AW = $clog2(DEPTH); ADDR_W = WORD_AW+2 (byte-address bits actually decoded).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; access was rejected.
- init_busy  out  1  array clear in progress.

Behaviour:
- Reset (async assert):
  - State enters INIT with the init counter at 0.
  - req_ready=0, init_busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All in-flight responses are discarded.
  - Reset asserted mid-INIT or mid-traffic restarts INIT from word 0.
- INIT:
  - Each cycle, write 0 to word[cnt], then cnt++.
  - After word DEPTH-1 is written, go to RUN next cycle.
  - INIT lasts exactly DEPTH cycles after reset deassertion.
- RUN:
  - req_ready=1, init_busy=0.
  - Accept on req_valid && req_ready, at most one request per cycle.
  - Back-to-back requests are legal every cycle.
- Requests in INIT are ignored: no state change and no response.
- Word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0]; lane 0 = bits [7:0].
- Error conditions (checked at acceptance):
  - req_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - On error: no array write, rsp_err=1, rsp_rdata=0.
- Store:
  - Byte store writes only lane addr[1:0].
  - Half store writes lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all lanes.
  - Lanes not written are preserved.
  - The write takes effect at the acceptance edge.
- Load:
  - Array is read at the acceptance edge.
  - The selected byte or half is shifted to the LSBs, then sign- or zero-extended per req_unsigned.
  - Word loads ignore req_unsigned.
- Response timing:
  - Every accepted request (load or store, error or not) produces exactly one rsp_valid pulse exactly READ_LAT cycles after its acceptance edge.
  - Responses are in order; there is no response backpressure.
  - Outside a pulse, rsp_rdata=0 and rsp_err=0.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data.

Optional Feature:
- Macro: DMEM_OOR_ERR_EN.
- Defined: a request with req_addr[31:ADDR_W]!=0 is out of range. It is treated like a misaligned access: no write, rsp_err=1, rsp_rdata=0.
- Undefined: req_addr[31:ADDR_W] is ignored and addresses alias modulo 4*DEPTH bytes, with no error.

Decomposition:
- Package dmem_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD).
  - Function for the alignment check.
  - Function for load lane-extract plus extension.
  - Function for store byte-enable generation and data replication.
  - INIT/RUN state enum.
- Sub-module dmem_rsp_pipe: a READ_LAT-deep shift register of {valid, rdata, err}, cleared asynchronously by rst.
- Top-level holds the array, the INIT FSM and the request decode.

Test Plan:
- Reset release with DEPTH=256 -> init_busy high for exactly 256 cycles and req_ready low throughout; a request issued during INIT yields no response. Then LW addr 0x10 -> rdata 0x00000000, err 0.
- SW 0x11223344 @0x20, then SB 0xAB @0x21, then LW @0x20 -> 0x1122AB44; with READ_LAT=3, each rsp_valid arrives 3 cycles after its acceptance.
- SW 0x80FF7F01 @0x40, then LB @0x42 -> 0xFFFFFFFF; LBU @0x42 -> 0x000000FF; LH @0x42 -> 0xFFFF80FF; LHU @0x40 -> 0x00007F01.
- LW @0x22, SH @0x23, size=11 -> each gives rsp_err=1 and rdata 0; a subsequent LW @0x20 shows the word unchanged.
- Addr 0x400 with DEPTH=256: with DMEM_OOR_ERR_EN, SW errors and word 0 is unchanged. Without it, SW 0xCAFEF00D @0x400 followed by LW @0x0 -> 0xCAFEF00D.
- Reset asserted while 2 loads are in flight -> rsp_valid stays 0 and INIT restarts from 0; earlier stored data reads 0 after INIT.
